// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer
// Address/control sequencer for one fully-connected layer. Streams input-word
// and weight read addresses for a runtime layer shape, delays a valid/first/last
// tag through a PIPE_LAT-deep pipe to drive the MAC, and writes each finished
// output group round-robin across NUM_BANKS output SRAMs.
// Optional feature macro: FC_SEQ_STALL_CNT_EN adds the stall_cnt output.
module fc_layer_sequencer #(
  parameter int DADDR_W   = 10,
  parameter int WADDR_W   = 15,
  parameter int OADDR_W   = 10,
  parameter int NUM_BANKS = 5,
  parameter int PIPE_LAT  = 3
) (
  input  logic                 clk,
  input  logic                 srstn,
`ifdef FC_SEQ_STALL_CNT_EN
  output logic [15:0]          stall_cnt,
`endif
  input  logic                 start,
  input  logic [DADDR_W-1:0]   cfg_in_words,
  input  logic [OADDR_W-1:0]   cfg_out_groups,
  input  logic [WADDR_W-1:0]   cfg_wbase,
  input  logic [OADDR_W-1:0]   cfg_obase,
  input  logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [DADDR_W-1:0]   data_raddr,
  output logic [WADDR_W-1:0]   weight_raddr,
  output logic                 rd_valid,
  output logic                 mac_en,
  output logic                 acc_clear,
  output logic [NUM_BANKS-1:0] out_wen_n,
  output logic [OADDR_W-1:0]   out_waddr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_s;

  // Latched layer configuration
  logic [DADDR_W-1:0]   in_words_r;
  logic [OADDR_W-1:0]   groups_r;
  logic [OADDR_W-1:0]   obase_r;

  // Issue counters
  logic [DADDR_W-1:0]   w_r;
  logic [OADDR_W-1:0]   g_r;
  logic [WADDR_W-1:0]   waddr_r;

  // Operand-latency pipe tags
  logic [PIPE_LAT-1:0]  pipe_v_r;
  logic [PIPE_LAT-1:0]  pipe_f_r;
  logic [PIPE_LAT-1:0]  pipe_l_r;

  // Output write side
  logic [2:0]           bank_r;
  logic [OADDR_W-1:0]   row_r;
  logic [NUM_BANKS-1:0] out_wen_n_r;
  logic [OADDR_W-1:0]   out_waddr_r;
  logic                 cfg_err_r;

  logic                 cfg_zero_s;
  logic                 accept_s;
  logic                 issue_s;
  logic                 last_word_s;
  logic                 last_grp_s;
  logic                 wr_launch_s;
  logic                 wr_act_s;

  assign cfg_zero_s  = (cfg_in_words == {DADDR_W{1'b0}}) || (cfg_out_groups == {OADDR_W{1'b0}});
  assign accept_s    = (state_r == ST_IDLE) && start && !cfg_zero_s;
  assign issue_s     = (state_r == ST_ISSUE) && !stall;
  assign last_word_s = (w_r == in_words_r - DADDR_W'(1));
  assign last_grp_s  = (g_r == groups_r - OADDR_W'(1));
  assign wr_launch_s = pipe_v_r[PIPE_LAT-1] & pipe_l_r[PIPE_LAT-1];
  assign wr_act_s    = (out_wen_n_r != {NUM_BANKS{1'b1}});

  assign data_raddr   = w_r;
  assign weight_raddr = waddr_r;
  assign mac_en       = pipe_v_r[PIPE_LAT-1];
  assign acc_clear    = pipe_v_r[PIPE_LAT-1] & pipe_f_r[PIPE_LAT-1];
  assign out_wen_n    = out_wen_n_r;
  assign out_waddr    = out_waddr_r;
  assign cfg_err      = cfg_err_r;

  // State register
  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and state-decoded outputs; the final write in DRAIN is the one
  // that leaves the pipe empty behind it
  always_comb begin
    state_s  = state_r;
    rd_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        busy     = 1'b1;
        rd_valid = !stall;
        if (issue_s && last_word_s && last_grp_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (wr_act_s && !(|pipe_v_r)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Capture the layer configuration when a start is accepted
  always_ff @(posedge clk) begin
    if (!srstn) begin
      in_words_r <= {DADDR_W{1'b0}};
      groups_r   <= {OADDR_W{1'b0}};
      obase_r    <= {OADDR_W{1'b0}};
    end else if (accept_s) begin
      in_words_r <= cfg_in_words;
      groups_r   <= cfg_out_groups;
      obase_r    <= cfg_obase;
    end
  end

  // Word/group counters and the linear weight address; frozen while stalled
  always_ff @(posedge clk) begin
    if (!srstn) begin
      w_r     <= {DADDR_W{1'b0}};
      g_r     <= {OADDR_W{1'b0}};
      waddr_r <= {WADDR_W{1'b0}};
    end else if (accept_s) begin
      w_r     <= {DADDR_W{1'b0}};
      g_r     <= {OADDR_W{1'b0}};
      waddr_r <= cfg_wbase;
    end else if (issue_s) begin
      waddr_r <= waddr_r + WADDR_W'(1);
      if (last_word_s) begin
        w_r <= {DADDR_W{1'b0}};
        g_r <= g_r + OADDR_W'(1);
      end else begin
        w_r <= w_r + DADDR_W'(1);
      end
    end
  end

  // Free-running tag pipe matching the operand read latency; stalls enter as bubbles
  always_ff @(posedge clk) begin
    if (!srstn) begin
      pipe_v_r <= {PIPE_LAT{1'b0}};
      pipe_f_r <= {PIPE_LAT{1'b0}};
      pipe_l_r <= {PIPE_LAT{1'b0}};
    end else begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        pipe_v_r[i] <= pipe_v_r[i-1];
        pipe_f_r[i] <= pipe_f_r[i-1];
        pipe_l_r[i] <= pipe_l_r[i-1];
      end
      pipe_v_r[0] <= rd_valid;
      pipe_f_r[0] <= rd_valid & (w_r == {DADDR_W{1'b0}});
      pipe_l_r[0] <= rd_valid & last_word_s;
    end
  end

  // Output write one cycle after a group's last MAC; bank/row counters replace g mod/div NUM_BANKS
  always_ff @(posedge clk) begin
    if (!srstn) begin
      bank_r      <= 3'd0;
      row_r       <= {OADDR_W{1'b0}};
      out_wen_n_r <= {NUM_BANKS{1'b1}};
      out_waddr_r <= {OADDR_W{1'b0}};
    end else if (accept_s) begin
      bank_r      <= 3'd0;
      row_r       <= {OADDR_W{1'b0}};
      out_wen_n_r <= {NUM_BANKS{1'b1}};
    end else if (wr_launch_s) begin
      out_wen_n_r <= ~(NUM_BANKS'(1'b1) << bank_r);
      out_waddr_r <= obase_r + row_r;
      if (bank_r == 3'(NUM_BANKS - 1)) begin
        bank_r <= 3'd0;
        row_r  <= row_r + OADDR_W'(1);
      end else begin
        bank_r <= bank_r + 3'd1;
      end
    end else begin
      out_wen_n_r <= {NUM_BANKS{1'b1}};
    end
  end

  // One-cycle error pulse for a start carrying a zero size field
  always_ff @(posedge clk) begin
    if (!srstn) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= (state_r == ST_IDLE) && start && cfg_zero_s;
    end
  end

`ifdef FC_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_r;
  assign stall_cnt = stall_cnt_r;

  // Saturating count of stalled issue cycles for the current layer
  always_ff @(posedge clk) begin
    if (!srstn) begin
      stall_cnt_r <= 16'd0;
    end else if (accept_s) begin
      stall_cnt_r <= 16'd0;
    end else if ((state_r == ST_ISSUE) && stall && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer (PIPE_LAT=3, NUM_BANKS=5).
// Cycle 0 is the cycle in which start is held high; outputs of cycle k are
// captured mid-period and compared against hand-derived expectations.
module tb_fc_layer_sequencer;

  logic        clk;
  logic        srstn;
  logic        start;
  logic [9:0]  cfg_in_words;
  logic [9:0]  cfg_out_groups;
  logic [14:0] cfg_wbase;
  logic [9:0]  cfg_obase;
  logic        stall;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [9:0]  data_raddr;
  logic [14:0] weight_raddr;
  logic        rd_valid;
  logic        mac_en;
  logic        acc_clear;
  logic [4:0]  out_wen_n;
  logic [9:0]  out_waddr;
`ifdef FC_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks;
  int n_fail;

  logic [31:0] obs_rdv  [0:31];
  logic [31:0] obs_da   [0:31];
  logic [31:0] obs_wa   [0:31];
  logic [31:0] obs_mac  [0:31];
  logic [31:0] obs_clr  [0:31];
  logic [31:0] obs_wen  [0:31];
  logic [31:0] obs_oa   [0:31];
  logic [31:0] obs_done [0:31];
  logic [31:0] obs_busy [0:31];
  logic [31:0] obs_err  [0:31];

  fc_layer_sequencer #(
    .DADDR_W(10), .WADDR_W(15), .OADDR_W(10), .NUM_BANKS(5), .PIPE_LAT(3)
  ) u_dut (
    .clk(clk),
    .srstn(srstn),
`ifdef FC_SEQ_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .start(start),
    .cfg_in_words(cfg_in_words),
    .cfg_out_groups(cfg_out_groups),
    .cfg_wbase(cfg_wbase),
    .cfg_obase(cfg_obase),
    .stall(stall),
    .busy(busy),
    .done(done),
    .cfg_err(cfg_err),
    .data_raddr(data_raddr),
    .weight_raddr(weight_raddr),
    .rd_valid(rd_valid),
    .mac_en(mac_en),
    .acc_clear(acc_clear),
    .out_wen_n(out_wen_n),
    .out_waddr(out_waddr)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required to finish");
    $fatal(1, "time limit reached");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start a layer at cycle 0, then capture cycles 1..n
  task automatic run_layer(input int iw, input int og, input int wb, input int ob,
                           input logic [31:0] stall_mask, input int glitch_cyc,
                           input int rst_cyc, input int n);
    @(posedge clk); #1;
    start          = 1'b1;
    cfg_in_words   = 10'(iw);
    cfg_out_groups = 10'(og);
    cfg_wbase      = 15'(wb);
    cfg_obase      = 10'(ob);
    stall          = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      start = (k == glitch_cyc);
      if (k == glitch_cyc) begin
        cfg_in_words   = 10'd9;
        cfg_out_groups = 10'd3;
        cfg_wbase      = 15'd5;
      end
      stall = stall_mask[k];
      srstn = (k != rst_cyc);
      #1;
      obs_rdv[k]  = 32'(rd_valid);
      obs_da[k]   = 32'(data_raddr);
      obs_wa[k]   = 32'(weight_raddr);
      obs_mac[k]  = 32'(mac_en);
      obs_clr[k]  = 32'(acc_clear);
      obs_wen[k]  = 32'(out_wen_n);
      obs_oa[k]   = 32'(out_waddr);
      obs_done[k] = 32'(done);
      obs_busy[k] = 32'(busy);
      obs_err[k]  = 32'(cfg_err);
    end
    start = 1'b0;
    stall = 1'b0;
    srstn = 1'b1;
  endtask

  // Expectations for the 4-word x 2-group layer, wbase 100, obase 8, no stall
  task automatic check_s1(input string pfx);
    logic [31:0] e_wen;
    for (int k = 1; k <= 14; k++) begin
      check_val($sformatf("%s rd_valid c%0d", pfx, k), obs_rdv[k], 32'(k <= 8));
      if (k <= 8) begin
        check_val($sformatf("%s data_raddr c%0d", pfx, k), obs_da[k], 32'((k - 1) % 4));
        check_val($sformatf("%s weight_raddr c%0d", pfx, k), obs_wa[k], 32'(99 + k));
      end
      check_val($sformatf("%s mac_en c%0d", pfx, k), obs_mac[k], 32'(k >= 4 && k <= 11));
      check_val($sformatf("%s acc_clear c%0d", pfx, k), obs_clr[k], 32'(k == 4 || k == 8));
      e_wen = (k == 8) ? 32'h1E : ((k == 12) ? 32'h1D : 32'h1F);
      check_val($sformatf("%s out_wen_n c%0d", pfx, k), obs_wen[k], e_wen);
      if (k == 8 || k == 12) begin
        check_val($sformatf("%s out_waddr c%0d", pfx, k), obs_oa[k], 32'd8);
      end
      check_val($sformatf("%s done c%0d", pfx, k), obs_done[k], 32'(k == 13));
      check_val($sformatf("%s busy c%0d", pfx, k), obs_busy[k], 32'(k <= 13));
    end
  endtask

  int          bank_tab [0:6];
  int          addr_tab [0:6];
  int          wrap_tab [0:3];
  logic [31:0] e_w;

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    srstn          = 1'b0;
    start          = 1'b0;
    stall          = 1'b0;
    cfg_in_words   = 10'd0;
    cfg_out_groups = 10'd0;
    cfg_wbase      = 15'd0;
    cfg_obase      = 10'd0;
    bank_tab = '{0, 1, 2, 3, 4, 0, 1};
    addr_tab = '{20, 20, 20, 20, 20, 21, 21};
    wrap_tab = '{32766, 32767, 0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check_val("rst busy", 32'(busy), 32'd0);
    check_val("rst done", 32'(done), 32'd0);
    check_val("rst cfg_err", 32'(cfg_err), 32'd0);
    check_val("rst rd_valid", 32'(rd_valid), 32'd0);
    check_val("rst mac_en", 32'(mac_en), 32'd0);
    check_val("rst acc_clear", 32'(acc_clear), 32'd0);
    check_val("rst out_wen_n", 32'(out_wen_n), 32'h1F);
    check_val("rst data_raddr", 32'(data_raddr), 32'd0);
    check_val("rst weight_raddr", 32'(weight_raddr), 32'd0);
    check_val("rst out_waddr", 32'(out_waddr), 32'd0);
    srstn = 1'b1;

    // Nominal layer
    run_layer(4, 2, 100, 8, 32'h0, 0, 0, 14);
    check_s1("s1");

    // Round-robin banks over 7 single-word groups
    run_layer(1, 7, 0, 20, 32'h0, 0, 0, 13);
    for (int k = 4; k <= 10; k++) begin
      check_val($sformatf("rr acc_clear c%0d", k), obs_clr[k], 32'd1);
    end
    for (int j = 0; j < 7; j++) begin
      e_w = 32'h1F;
      e_w[bank_tab[j]] = 1'b0;
      check_val($sformatf("rr out_wen_n c%0d", j + 5), obs_wen[j + 5], e_w);
      check_val($sformatf("rr out_waddr c%0d", j + 5), obs_oa[j + 5], 32'(addr_tab[j]));
    end
    check_val("rr done c12", obs_done[12], 32'd1);
    check_val("rr done c11", obs_done[11], 32'd0);
    check_val("rr busy c13", obs_busy[13], 32'd0);

    // Stall at cycles 2-3
    run_layer(4, 2, 100, 8, 32'h0000_000C, 0, 0, 16);
    for (int k = 1; k <= 16; k++) begin
      check_val($sformatf("st rd_valid c%0d", k), obs_rdv[k], 32'(k == 1 || (k >= 4 && k <= 10)));
      if (k == 1) begin
        check_val("st weight_raddr c1", obs_wa[k], 32'd100);
      end else if (k >= 4 && k <= 10) begin
        check_val($sformatf("st data_raddr c%0d", k), obs_da[k], 32'((k - 3) % 4));
        check_val($sformatf("st weight_raddr c%0d", k), obs_wa[k], 32'(97 + k));
      end
      check_val($sformatf("st mac_en c%0d", k), obs_mac[k], 32'(k == 4 || (k >= 7 && k <= 13)));
      check_val($sformatf("st acc_clear c%0d", k), obs_clr[k], 32'(k == 4 || k == 10));
      e_w = (k == 10) ? 32'h1E : ((k == 14) ? 32'h1D : 32'h1F);
      check_val($sformatf("st out_wen_n c%0d", k), obs_wen[k], e_w);
      check_val($sformatf("st done c%0d", k), obs_done[k], 32'(k == 15));
      check_val($sformatf("st busy c%0d", k), obs_busy[k], 32'(k <= 15));
    end
`ifdef FC_SEQ_STALL_CNT_EN
    check_val("st stall_cnt", 32'(stall_cnt), 32'd2);
`endif

    // Zero config fields
    run_layer(0, 3, 0, 0, 32'h0, 0, 0, 3);
    for (int k = 1; k <= 3; k++) begin
      check_val($sformatf("ze cfg_err c%0d", k), obs_err[k], 32'(k == 1));
      check_val($sformatf("ze busy c%0d", k), obs_busy[k], 32'd0);
      check_val($sformatf("ze rd_valid c%0d", k), obs_rdv[k], 32'd0);
    end
    run_layer(2, 0, 0, 0, 32'h0, 0, 0, 2);
    check_val("zg cfg_err c1", obs_err[1], 32'd1);
    check_val("zg cfg_err c2", obs_err[2], 32'd0);
    check_val("zg busy c1", obs_busy[1], 32'd0);

    // Reset during the nominal layer, then a clean rerun
    run_layer(4, 2, 100, 8, 32'h0, 0, 5, 14);
    for (int k = 1; k <= 5; k++) begin
      check_val($sformatf("mr rd_valid c%0d", k), obs_rdv[k], 32'd1);
      check_val($sformatf("mr data_raddr c%0d", k), obs_da[k], 32'((k - 1) % 4));
    end
    for (int k = 6; k <= 14; k++) begin
      check_val($sformatf("mr busy c%0d", k), obs_busy[k], 32'd0);
      check_val($sformatf("mr rd_valid c%0d", k), obs_rdv[k], 32'd0);
      check_val($sformatf("mr mac_en c%0d", k), obs_mac[k], 32'd0);
      check_val($sformatf("mr acc_clear c%0d", k), obs_clr[k], 32'd0);
      check_val($sformatf("mr out_wen_n c%0d", k), obs_wen[k], 32'h1F);
      check_val($sformatf("mr done c%0d", k), obs_done[k], 32'd0);
      check_val($sformatf("mr weight_raddr c%0d", k), obs_wa[k], 32'd0);
      check_val($sformatf("mr data_raddr c%0d", k), obs_da[k], 32'd0);
    end
    run_layer(4, 2, 100, 8, 32'h0, 0, 0, 14);
    check_s1("rr1");

    // Weight address wrap, with an ignored start during issue
    run_layer(4, 1, 32766, 3, 32'h0, 2, 0, 11);
    for (int k = 1; k <= 4; k++) begin
      check_val($sformatf("wr weight_raddr c%0d", k), obs_wa[k], 32'(wrap_tab[k - 1]));
      check_val($sformatf("wr data_raddr c%0d", k), obs_da[k], 32'(k - 1));
    end
    for (int k = 1; k <= 11; k++) begin
      check_val($sformatf("wr rd_valid c%0d", k), obs_rdv[k], 32'(k <= 4));
      check_val($sformatf("wr done c%0d", k), obs_done[k], 32'(k == 9));
      check_val($sformatf("wr busy c%0d", k), obs_busy[k], 32'(k <= 9));
    end
    check_val("wr out_wen_n c8", obs_wen[8], 32'h1E);
    check_val("wr out_waddr c8", obs_oa[8], 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_layer_sequencer.md
# fc_layer_sequencer

Parametrised address/control sequencer for one fully-connected layer in the LeNet accelerator datapath. On each accepted start it streams input-word and weight addresses for a runtime-configured layer shape, drives MAC enable and clear through a configurable read latency, and writes each output group round-robin across NUM_BANKS output SRAMs. It generalises the fixed FC1/FC2 controller: layer sizes are runtime inputs, the pipeline depth and bank count are parameters, and issue can be stalled by arbitration.

## Interface
- DADDR_W, 10, input-data read address width
- WADDR_W, 15, weight read address width
- OADDR_W, 10, output write address width
- NUM_BANKS, 5, output SRAM banks written round-robin (1..8)
- PIPE_LAT, 3, cycles from address issue to operand valid at MAC (1..8)

Ports:
- clk  in  1  clock
- srstn  in  1  synchronous active-low reset
- start  in  1  start pulse; accepted only in IDLE
- cfg_in_words  in  DADDR_W  input words per output group (>=1)
- cfg_out_groups  in  OADDR_W  output groups in layer (>=1)
- cfg_wbase  in  WADDR_W  first weight address
- cfg_obase  in  OADDR_W  first output address in each bank
- stall  in  1  hold issue this cycle
- busy  out  1  high from ISSUE entry through DONE
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  one-cycle pulse: start with a zero config field
- data_raddr  out  DADDR_W  input-word read address
- weight_raddr  out  WADDR_W  weight read address
- rd_valid  out  1  addresses valid this cycle
- mac_en  out  1  operands valid at MAC
- acc_clear  out  1  with first mac_en of each group
- out_wen_n  out  NUM_BANKS  active-low per-bank write enable
- out_waddr  out  OADDR_W  output write address

## Operation
- States: IDLE, ISSUE, DRAIN, DONE. Config latched on start acceptance; inputs ignored afterwards.
- IDLE: start with both cfg_in_words, cfg_out_groups nonzero -> ISSUE; either zero -> cfg_err pulse next cycle, stay IDLE.
- ISSUE: word counter w 0..cfg_in_words-1, group counter g 0..cfg_out_groups-1. data_raddr = w; weight_raddr = cfg_wbase + g*cfg_in_words + w, kept as a linear incrementing counter, wraps mod 2^WADDR_W. w wraps to 0 and g increments after the last word. After the last issue (g, w both final) -> DRAIN.
- stall=1 in ISSUE: counters hold, rd_valid=0, a bubble enters the pipeline. The pipeline always advances and stall does not affect it.
- Pipeline: PIPE_LAT-deep shift register of {valid, first, last}. mac_en = delayed valid. acc_clear = delayed valid&first. On delayed valid&last, the next cycle drives out_wen_n[bank]=0 with out_waddr = cfg_obase + row. bank = g mod NUM_BANKS and row = g div NUM_BANKS, both from a bank counter and row counter (no divider).
- DRAIN -> DONE in the cycle the final write is driven. DONE lasts one cycle (done=1) -> IDLE.
- start outside IDLE is ignored. Reset mid-operation: immediate return to IDLE, pipeline flushed, no further writes.
- Reset values: busy, done, cfg_err, rd_valid, mac_en, acc_clear = 0. out_wen_n all 1. Addresses 0.

## Timing
- start sampled at cycle 0 -> first rd_valid at cycle 1.
- mac_en lags rd_valid by exactly PIPE_LAT cycles.
- Output write lags the last-word issue by PIPE_LAT+1 cycles.
- done = final write cycle + 1. busy falls the cycle after done.
- No-stall layer duration: in_words*out_groups + PIPE_LAT + 2 cycles from acceptance to done.
- cfg_err is asserted at cycle 1 when a start with a zero config field is sampled at cycle 0.

## Configuration
- FC_SEQ_STALL_CNT_EN defined: adds output stall_cnt [15:0]. It counts cycles with stall=1 in ISSUE, saturates at 16'hFFFF, clears on start acceptance, and holds after done. Reset value 0.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- PIPE_LAT=3, NUM_BANKS=5; in_words=4, out_groups=2, wbase=100, obase=8, start at cycle 0.
  - weight_raddr 100..107 and data_raddr 0,1,2,3,0,1,2,3 over cycles 1-8.
  - mac_en high cycles 4-11, acc_clear at 4 and 8.
  - out_wen_n[0]=0 with addr 8 at cycle 12's predecessor (cycle 8); out_wen_n[1]=0 with addr 8 at cycle 12.
  - done at cycle 13.
- out_groups=7, in_words=1, NUM_BANKS=5 -> banks 0,1,2,3,4,0,1 written at addrs obase, obase, obase, obase, obase, obase+1, obase+1.
- Same shape as scenario 1 with stall high at cycles 2-3 -> issue extends to cycle 10, mac_en gap at cycles 5-6, done at 15. With macro defined, stall_cnt=2.
- start with cfg_in_words=0 -> cfg_err pulse at cycle 1, busy stays 0, no rd_valid.
- srstn low at cycle 5 of scenario 1 -> all outputs at reset values next cycle, no out_wen_n low afterwards. A subsequent start runs the layer cleanly.
- wbase=32766, in_words=4, out_groups=1 -> weight_raddr 32766, 32767, 0, 1. A start pulse during ISSUE is ignored.
